// File: rtl/ex_mem_skid.sv
// ex_mem_skid
// -----------------------------------------------------------------------------
// EX->MEM pipeline stage built as a two-entry skid buffer with a valid/ready
// handshake on both sides. The head entry drives the MEM-side outputs; the
// skid entry only catches the one instruction EX may launch in the cycle
// where MEM stalls. Because ex_ready is a flop derived from the next
// occupancy, there is no combinational path from mem_ready back to EX.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               drop every held entry and any transfer this cycle
//   ex_valid/ex_ready   EX-side handshake (ex_ready is registered)
//   ex_wd/ex_wreg/ex_wdata                   write-back triple from EX
//   ex_memop/ex_maddr/ex_sdata               memory-op descriptor from EX
//   mem_valid/mem_ready MEM-side handshake on the head entry
//   mem_*               head entry fields, forced to 0 when mem_valid=0
//   fwd_hit_valid/fwd_wd/fwd_wdata  bypass for the EX forwarding network
//   occupancy           number of held entries, 0..2
// -----------------------------------------------------------------------------
module ex_mem_skid #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,

   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic [1:0]            ex_memop,
   input  logic [DATA_W-1:0]     ex_maddr,
   input  logic [DATA_W-1:0]     ex_sdata,

   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [1:0]            mem_memop,
   output logic [DATA_W-1:0]     mem_maddr,
   output logic [DATA_W-1:0]     mem_sdata,

   output logic                  fwd_hit_valid,
   output logic [REG_ADDR_W-1:0] fwd_wd,
   output logic [DATA_W-1:0]     fwd_wdata,

   output logic [1:0]            occupancy
);

   localparam int ENTRY_W = REG_ADDR_W + 1 + DATA_W + 2 + DATA_W + DATA_W;

   localparam logic [1:0] MEMOP_NONE     = 2'd0;
   localparam logic [1:0] MEMOP_LOAD     = 2'd1;
   localparam logic [1:0] MEMOP_RESERVED = 2'd3;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   occ_t               state_q, state_d;
   logic               ex_ready_q, ex_ready_d;
   logic [ENTRY_W-1:0] head_q, head_d;
   logic [ENTRY_W-1:0] skid_q, skid_d;

   logic [1:0]         in_memop;
   logic [ENTRY_W-1:0] in_entry;
   logic               accept;
   logic               pop;
   logic               head_valid;

   logic [REG_ADDR_W-1:0] h_wd;
   logic                  h_wreg;
   logic [DATA_W-1:0]     h_wdata;
   logic [1:0]            h_memop;
   logic [DATA_W-1:0]     h_maddr;
   logic [DATA_W-1:0]     h_sdata;

   // Reserved encoding is normalised on entry so MEM never sees it.
   assign in_memop = (ex_memop == MEMOP_RESERVED) ? MEMOP_NONE : ex_memop;
   assign in_entry = {ex_wd, ex_wreg, ex_wdata, in_memop, ex_maddr, ex_sdata};

   assign head_valid = (state_q != OCC_EMPTY);
   assign accept     = ex_valid && ex_ready_q && !flush;
   assign pop        = head_valid && mem_ready && !flush;

   // Next-state / storage steering
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;

      case (state_q)
         OCC_EMPTY: begin
            if (accept) begin
               head_d  = in_entry;
               state_d = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (accept && pop) begin
               head_d = in_entry;           // old head leaves, new one takes its place
            end else if (accept) begin
               skid_d  = in_entry;
               state_d = OCC_FULL;
            end else if (pop) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            // ex_ready_q is low here, so accept cannot be set.
            if (pop) begin
               head_d  = skid_q;
               skid_d  = '0;
               state_d = OCC_ONE;
            end
         end
         default: begin
            state_d = OCC_EMPTY;
         end
      endcase

      if (flush) begin
         state_d = OCC_EMPTY;
         head_d  = '0;
         skid_d  = '0;
      end

      // Registered ready: derived from where occupancy lands after this edge.
      ex_ready_d = (state_d != OCC_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= OCC_EMPTY;
         ex_ready_q <= 1'b1;
         head_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         ex_ready_q <= ex_ready_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
      end
   end

   assign {h_wd, h_wreg, h_wdata, h_memop, h_maddr, h_sdata} = head_q;

   // Bubble gating: outputs are clean zeros whenever no entry is presented.
   always_comb begin
      mem_valid = head_valid;
      mem_wd    = '0;
      mem_wreg  = 1'b0;
      mem_wdata = '0;
      mem_memop = MEMOP_NONE;
      mem_maddr = '0;
      mem_sdata = '0;
      if (head_valid) begin
         mem_wd    = h_wd;
         mem_wreg  = h_wreg;
         mem_wdata = h_wdata;
         mem_memop = h_memop;
         mem_maddr = h_maddr;
         mem_sdata = h_sdata;
      end
   end

   // Loads are not forwardable (value unknown until MEM), and r0 is never a
   // real destination. The skid entry is deliberately excluded: EX is held
   // off while FULL, so no younger instruction can depend on it.
   always_comb begin
      fwd_hit_valid = head_valid && h_wreg && (h_wd != '0) && (h_memop != MEMOP_LOAD);
      fwd_wd        = '0;
      fwd_wdata     = '0;
      if (fwd_hit_valid) begin
         fwd_wd    = h_wd;
         fwd_wdata = h_wdata;
      end
   end

   assign ex_ready  = ex_ready_q;
   assign occupancy = state_q;

endmodule
